// File: rtl/icache_dm_if.sv
// Fetch-side and memory-side port bundles for the direct-mapped instruction cache.
// fetch: master = IF stage, slave = cache. mem: master = cache, slave = instruction memory.
interface icache_fetch_if;
    logic [11:0] icache_req_addr;
    logic        icache_req_valid;
    logic        icache_req_rw;
    logic        icache_flush;
    logic [31:0] icache_data_read;
    logic        icache_ready;
    logic        icache_hit;

    modport master (
        output icache_req_addr, icache_req_valid, icache_req_rw, icache_flush,
        input  icache_data_read, icache_ready, icache_hit
    );
    modport slave (
        input  icache_req_addr, icache_req_valid, icache_req_rw, icache_flush,
        output icache_data_read, icache_ready, icache_hit
    );
endinterface

interface icache_mem_if;
    logic        mem_req_valid;
    logic [11:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output mem_req_valid, mem_req_addr,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );
    modport slave (
        input  mem_req_valid, mem_req_addr,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );
endinterface

// File: rtl/icache_dm.sv
// Direct-mapped read-only instruction cache; hits served in the request cycle, misses refill one line.
// Optional ICACHE_STATS_EN adds stat_hit_cnt / stat_miss_cnt counters.
module icache_dm #(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned LINES      = 64
) (
    input  logic          clk,
    input  logic          rst,
    icache_fetch_if.slave fetch,
    icache_mem_if.master  mem
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0]   stat_hit_cnt,
    output logic [31:0]   stat_miss_cnt
`endif
);

    localparam int unsigned ADDR_W = 12;
    localparam int unsigned OFF_W  = $clog2(LINE_WORDS);
    localparam int unsigned IDX_W  = $clog2(LINES);
    localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int unsigned LINE_W = ADDR_W - OFF_W;
    localparam int unsigned WIDX_W = IDX_W + OFF_W;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FILL} state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*LINE_WORDS];
    logic [LINE_W-1:0]   line_q;
    logic [OFF_W-1:0]    cnt_q;
    logic                flushed_q;

    logic                start_miss, word_we, fill_en, lookup_hit;
    logic [TAG_W-1:0]    req_tag;
    logic [IDX_W-1:0]    req_idx;
    logic [WIDX_W-1:0]   req_widx;
    logic [IDX_W-1:0]    fill_idx;
    logic [TAG_W-1:0]    fill_tag;

    assign req_tag    = fetch.icache_req_addr[ADDR_W-1 -: TAG_W];
    assign req_idx    = fetch.icache_req_addr[OFF_W +: IDX_W];
    assign req_widx   = fetch.icache_req_addr[WIDX_W-1:0];
    assign fill_idx   = line_q[IDX_W-1:0];
    assign fill_tag   = line_q[LINE_W-1 -: TAG_W];
    assign lookup_hit = valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

    // Next state and fetch/memory port outputs
    always_comb begin
        state_d                = state_q;
        fetch.icache_data_read = NOP;
        fetch.icache_ready     = 1'b0;
        fetch.icache_hit       = 1'b1;
        mem.mem_req_valid      = 1'b0;
        mem.mem_req_addr       = '0;
        start_miss             = 1'b0;
        word_we                = 1'b0;
        fill_en                = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (fetch.icache_req_valid) begin
                    if (fetch.icache_req_rw) begin
                        fetch.icache_ready = 1'b1;
                        fetch.icache_hit   = 1'b0;
                    end else if (lookup_hit) begin
                        fetch.icache_ready     = 1'b1;
                        fetch.icache_hit       = 1'b0;
                        fetch.icache_data_read = data_mem[req_widx];
                    end else begin
                        start_miss = 1'b1;
                        state_d    = S_REQ;
                    end
                end
            end
            S_REQ: begin
                mem.mem_req_valid = 1'b1;
                mem.mem_req_addr  = {line_q, cnt_q};
                if (mem.mem_req_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (mem.mem_resp_valid) begin
                    word_we = 1'b1;
                    state_d = (cnt_q == LAST_WORD) ? S_FILL : S_REQ;
                end
            end
            S_FILL: begin
                fill_en = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, refill bookkeeping and valid bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            valid_q   <= '0;
            line_q    <= '0;
            cnt_q     <= '0;
            flushed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_miss) begin
                line_q    <= fetch.icache_req_addr[ADDR_W-1:OFF_W];
                cnt_q     <= '0;
                flushed_q <= 1'b0;
            end else if (word_we && (cnt_q != LAST_WORD)) begin
                cnt_q <= cnt_q + OFF_W'(1);
            end
            // A flush seen while refilling keeps the refilled line invalid
            if ((state_q != S_IDLE) && fetch.icache_flush) flushed_q <= 1'b1;
            if (fetch.icache_flush)         valid_q           <= '0;
            else if (fill_en && !flushed_q) valid_q[fill_idx] <= 1'b1;
        end
    end

    // Tag and data arrays need no reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (word_we) data_mem[{fill_idx, cnt_q}] <= mem.mem_resp_data;
        if (fill_en) tag_mem[fill_idx]           <= fill_tag;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_hit_cnt  <= '0;
            stat_miss_cnt <= '0;
        end else begin
            if ((state_q == S_IDLE) && fetch.icache_req_valid && !fetch.icache_req_rw && lookup_hit)
                stat_hit_cnt <= stat_hit_cnt + 32'd1;
            if (start_miss)
                stat_miss_cnt <= stat_miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: expected fetch data and memory request addresses are queued at issue
// and popped by monitors when the cache presents ready or the memory model accepts a request.
module tb_icache_dm;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic clk;
    logic rst;

    icache_fetch_if fif();
    icache_mem_if   mif();

`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hit_cnt;
    logic [31:0] stat_miss_cnt;
`endif

    icache_dm dut (
        .clk   (clk),
        .rst   (rst),
        .fetch (fif),
        .mem   (mif)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hit_cnt  (stat_hit_cnt),
        .stat_miss_cnt (stat_miss_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] resp_q[$];
    logic [11:0] memreq_q[$];

    int rdy_delay = 0;
    int resp_lat  = 1;
    bit flush_arm = 1'b0;
    bit flush_done;
    int acc_cnt;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    // Fetch-side monitor: every ready cycle must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst === 1'b1 && fif.icache_ready === 1'b1) begin
            if (resp_q.size() == 0) begin
                chk("unexpected_ready", 64'(fif.icache_data_read), 64'(NOP + 32'hdead));
            end else begin
                chk("fetch_data", 64'(fif.icache_data_read), 64'(resp_q.pop_front()));
                chk("fetch_hit_low", 64'(fif.icache_hit), 64'd0);
            end
        end
    end

    // Memory model: word at address a holds 0x1000_0000 | a
    initial begin : mem_model
        logic [11:0] a;
        mif.mem_req_ready  = 1'b0;
        mif.mem_resp_valid = 1'b0;
        mif.mem_resp_data  = '0;
        fif.icache_flush   = 1'b0;
        flush_done         = 1'b0;
        acc_cnt            = 0;
        forever begin
            @(negedge clk);
            mif.mem_resp_valid = 1'b0;
            fif.icache_flush   = 1'b0;
            if (rst === 1'b1 && mif.mem_req_valid === 1'b1) begin
                a = mif.mem_req_addr;
                for (int s = 0; s < rdy_delay; s++) begin
                    @(negedge clk);
                    chk("req_stable", 64'({mif.mem_req_valid, mif.mem_req_addr}), 64'({1'b1, a}));
                end
                if (memreq_q.size() == 0) chk("unexpected_mem_req", 64'(a), 64'hfff0);
                else                      chk("mem_req_addr", 64'(a), 64'(memreq_q.pop_front()));
                acc_cnt++;
                mif.mem_req_ready = 1'b1;
                @(negedge clk);
                mif.mem_req_ready = 1'b0;
                chk("req_drop", 64'(mif.mem_req_valid), 64'd0);
                if (flush_arm && !flush_done && a[1:0] == 2'd1) begin
                    fif.icache_flush = 1'b1;
                    flush_done       = 1'b1;
                end
                for (int l = 1; l < resp_lat; l++) begin
                    @(negedge clk);
                    fif.icache_flush = 1'b0;
                end
                mif.mem_resp_valid = 1'b1;
                mif.mem_resp_data  = 32'h1000_0000 | 32'(a);
            end
        end
    end

    // Issue one fetch; refills = number of line refills expected before it is served
    task automatic fetch(input logic [11:0] a, input int refills, input logic [31:0] exp);
        int cyc;
        cyc = 0;
        fif.icache_req_addr  = a;
        fif.icache_req_rw    = 1'b0;
        fif.icache_req_valid = 1'b1;
        resp_q.push_back(exp);
        for (int r = 0; r < refills; r++)
            for (int w = 0; w < 4; w++) memreq_q.push_back({a[11:2], 2'(w)});
        forever begin
            @(negedge clk);
            if (fif.icache_ready === 1'b1 || cyc >= 400) break;
            chk("hold_outputs", 64'({fif.icache_hit, fif.icache_data_read}), 64'({1'b1, NOP}));
            cyc++;
        end
        chk("fetch_served", 64'(fif.icache_ready), 64'd1);
        chk("miss_vs_hit", 64'(cyc > 0), 64'(refills > 0));
        @(posedge clk);
        #1;
        fif.icache_req_valid = 1'b0;
    endtask

    initial begin : main
        int n0;
        rst                  = 1'b0;
        fif.icache_req_addr  = '0;
        fif.icache_req_valid = 1'b0;
        fif.icache_req_rw    = 1'b0;

        repeat (2) @(negedge clk);
        chk("rst_outputs",
            64'({fif.icache_data_read, fif.icache_ready, fif.icache_hit, mif.mem_req_valid, mif.mem_req_addr}),
            64'({NOP, 1'b0, 1'b1, 1'b0, 12'h000}));
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Cold miss, then the rest of the line hits
        fetch(12'h000, 1, 32'h1000_0000);
        fetch(12'h001, 0, 32'h1000_0001);
        fetch(12'h002, 0, 32'h1000_0002);
        fetch(12'h003, 0, 32'h1000_0003);
`ifdef ICACHE_STATS_EN
        chk("stat_hit_cnt", 64'(stat_hit_cnt), 64'd4);
        chk("stat_miss_cnt", 64'(stat_miss_cnt), 64'd1);
`endif

        // Conflict on index 0
        fetch(12'h000, 0, 32'h1000_0000);
        fetch(12'h100, 1, 32'h1000_0100);
        fetch(12'h000, 1, 32'h1000_0000);

        // Flush during the second word's wait: line left invalid, refilled once more
        resp_lat  = 3;
        flush_arm = 1'b1;
        fetch(12'h040, 2, 32'h1000_0040);
        flush_arm = 1'b0;
        fetch(12'h041, 0, 32'h1000_0041);

        // Slow request acceptance
        rdy_delay = 5;
        fetch(12'h3f8, 1, 32'h1000_03f8);
        rdy_delay = 0;
        fetch(12'h3fb, 0, 32'h1000_03fb);

        // Idle with no request
        fif.icache_req_addr = 12'h005;
        repeat (2) begin
            @(negedge clk);
            chk("idle_no_req", 64'({fif.icache_ready, fif.icache_hit, mif.mem_req_valid}), 64'(3'b010));
        end

        // Write request is a no-op
        @(posedge clk);
        #1;
        fif.icache_req_addr  = 12'h010;
        fif.icache_req_rw    = 1'b1;
        fif.icache_req_valid = 1'b1;
        resp_q.push_back(NOP);
        @(negedge clk);
        chk("rw_ready", 64'({fif.icache_ready, mif.mem_req_valid}), 64'(2'b10));
        @(posedge clk);
        #1;
        fif.icache_req_valid = 1'b0;
        fif.icache_req_rw    = 1'b0;
        @(negedge clk);
        chk("rw_no_refill", 64'(mif.mem_req_valid), 64'd0);

        // Reset in the middle of a refill; the late response must be ignored
        @(posedge clk);
        #1;
        fif.icache_req_addr  = 12'h080;
        fif.icache_req_valid = 1'b1;
        memreq_q.push_back(12'h080);
        n0 = acc_cnt;
        for (int i = 0; i < 50 && acc_cnt == n0; i++) begin
            @(negedge clk);
            #1;
        end
        chk("rst_test_accept", 64'(acc_cnt), 64'(n0 + 1));
        @(negedge clk);
        rst                  = 1'b0;
        fif.icache_req_valid = 1'b0;
        #1;
        chk("mid_refill_rst",
            64'({fif.icache_ready, fif.icache_hit, mif.mem_req_valid, fif.icache_data_read}),
            64'({3'b010, NOP}));
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_after_rst", 64'({fif.icache_ready, fif.icache_hit, mif.mem_req_valid}), 64'(3'b010));
        end
        @(posedge clk);
        #1;
        fetch(12'h3f8, 1, 32'h1000_03f8);
        fetch(12'h082, 1, 32'h1000_0082);

        repeat (3) @(negedge clk);
        chk("resp_q_drained", 64'(resp_q.size()), 64'd0);
        chk("memreq_q_drained", 64'(memreq_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
